// File: rtl/e_alu_mdu.sv
// e_alu_mdu: execute-stage ALU plus multi-cycle multiply/divide unit owning HI/LO.
//   clk, reset_n       : rising-edge clock, asynchronous active-low reset
//   A, B, shamt        : operands and instruction shift field
//   ALUCtrl            : ALU op select -> ALU_Result, Overflow (combinational)
//   MDUOp, start       : MDU op and its qualifier
//   busy, MDU_Stall    : MDU in flight / freeze request for the hazard unit
//   MDU_Result, HI, LO : MFHI/MFLO read data and the architectural registers
module e_alu_mdu #(
    parameter int WIDTH      = 32,
    parameter int SHW        = $clog2(WIDTH),
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       ALUCtrl,
    output logic [WIDTH-1:0] ALU_Result,
    output logic             Overflow,
    input  logic [3:0]       MDUOp,
    input  logic             start,
    output logic             busy,
    output logic             MDU_Stall,
    output logic [WIDTH-1:0] MDU_Result,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CMAX = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
    localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
    localparam logic [3:0] OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;
    localparam int M = WIDTH - 1;

    logic [SHW:0]       w_sh_sum;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_add, w_sub;
    // Register-supplied shift plus immediate shamt, wrapped to the datapath width.
    assign w_sh_sum = {1'b0, A[SHW-1:0]} + {1'b0, shamt};
    assign w_sh     = SHW'(w_sh_sum % (SHW+1)'(WIDTH));
    assign w_add    = A + B;
    assign w_sub    = A - B;

    always_comb begin
        ALU_Result = '0;
        case (ALUCtrl)
            4'd0:    ALU_Result = w_add;
            4'd1:    ALU_Result = w_sub;
            4'd2:    ALU_Result = A & B;
            4'd3:    ALU_Result = A | B;
            4'd4:    ALU_Result = A ^ B;
            4'd5:    ALU_Result = {{M{1'b0}}, $signed(A) < $signed(B)};
            4'd6:    ALU_Result = {{M{1'b0}}, A < B};
            4'd7:    ALU_Result = B << w_sh;
            4'd8:    ALU_Result = B >> w_sh;
            4'd9:    ALU_Result = $signed(B) >>> w_sh;
            4'd10:   ALU_Result = ~(A | B);
            4'd11:   ALU_Result = B << (WIDTH / 2);
            default: ALU_Result = '0;
        endcase
    end

    assign Overflow = ALUCtrl == 4'd0 ? (A[M] == B[M]) && (w_add[M] != A[M]) :
                      ALUCtrl == 4'd1 ? (A[M] != B[M]) && (w_sub[M] != A[M]) : 1'b0;

    logic [0:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
    logic               w_md_start, w_sgn, w_is_div;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_na, w_nb, w_q, w_r, w_quo, w_rem;

    assign w_md_start = start && MDUOp >= OP_MULT && MDUOp <= OP_DIVU;
    assign w_sgn      = r_op == OP_MULT || r_op == OP_DIV;
    assign w_is_div   = r_op == OP_DIV || r_op == OP_DIVU;
    // Sign-extending both operands lets one 2W-bit multiplier serve MULT and MULTU.
    assign w_prod = {{WIDTH{w_sgn & r_a[M]}}, r_a} * {{WIDTH{w_sgn & r_b[M]}}, r_b};
    // Signed divide on magnitudes; quotient sign from operand signs, remainder follows dividend.
    assign w_na  = (w_sgn & r_a[M]) ? -r_a : r_a;
    assign w_nb  = (w_sgn & r_b[M]) ? -r_b : r_b;
    assign w_q   = w_na / w_nb;
    assign w_r   = w_na % w_nb;
    assign w_quo = (w_sgn & (r_a[M] ^ r_b[M])) ? -w_q : w_q;
    assign w_rem = (w_sgn & r_a[M]) ? -w_r : w_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (r_state == IDLE) begin
            if (w_md_start) begin
                r_state <= RUN;
                r_op    <= MDUOp;
                r_a     <= A;
                r_b     <= B;
                r_cnt   <= MDUOp >= OP_DIV ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end else if (start && MDUOp == OP_MTHI) begin
                r_hi <= A;
            end else if (start && MDUOp == OP_MTLO) begin
                r_lo <= A;
            end
        end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                r_state <= IDLE;
                if (!w_is_div) begin
                    {r_hi, r_lo} <= w_prod;
                end else if (r_b != '0) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end
    end

    assign busy       = r_state == RUN;
    assign MDU_Stall  = busy | w_md_start;
    assign HI         = r_hi;
    assign LO         = r_lo;
    assign MDU_Result = !start ? '0 : MDUOp == OP_MFHI ? r_hi : MDUOp == OP_MFLO ? r_lo : '0;
endmodule

// File: tb/tb_e_alu_mdu.sv
// tb_e_alu_mdu: directed table-driven ALU checks plus MDU sequences on three parameterisations.
module tb_e_alu_mdu;
    logic        clk = 0, reset_n = 0;
    logic [31:0] A = 0, B = 0, ALU_Result, MDU_Result, HI, LO;
    logic [4:0]  shamt = 0;
    logic [3:0]  ALUCtrl = 0, MDUOp = 0;
    logic        start = 0, Overflow, busy, MDU_Stall;
    logic [15:0] a16 = 0, b16 = 0, alu16, mres16, hi16, lo16;
    logic [3:0]  op16 = 0;
    logic        start16 = 0, ov16, busy16, stall16;
    logic [7:0]  a8 = 0, b8 = 0, alu8, mres8, hi8, lo8;
    logic [2:0]  sh8 = 0;
    logic [3:0]  ctl8 = 0;
    logic        ov8, busy8, stall8;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    e_alu_mdu u_dut (.clk(clk), .reset_n(reset_n), .A(A), .B(B), .shamt(shamt), .ALUCtrl(ALUCtrl),
        .ALU_Result(ALU_Result), .Overflow(Overflow), .MDUOp(MDUOp), .start(start), .busy(busy),
        .MDU_Stall(MDU_Stall), .MDU_Result(MDU_Result), .HI(HI), .LO(LO));
    e_alu_mdu #(.WIDTH(16), .MUL_CYCLES(1)) u_w16 (.clk(clk), .reset_n(reset_n), .A(a16), .B(b16),
        .shamt(4'd0), .ALUCtrl(4'd0), .ALU_Result(alu16), .Overflow(ov16), .MDUOp(op16), .start(start16),
        .busy(busy16), .MDU_Stall(stall16), .MDU_Result(mres16), .HI(hi16), .LO(lo16));
    e_alu_mdu #(.WIDTH(8)) u_w8 (.clk(clk), .reset_n(reset_n), .A(a8), .B(b8), .shamt(sh8),
        .ALUCtrl(ctl8), .ALU_Result(alu8), .Overflow(ov8), .MDUOp(4'd0), .start(1'b0), .busy(busy8),
        .MDU_Stall(stall8), .MDU_Result(mres8), .HI(hi8), .LO(lo8));

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        ov;
    } vec_t;
    vec_t v[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where busy has fallen.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, b, input int n_exp);
        int n;
        A = a; B = b; MDUOp = op; start = 1;
        #1 chk({name, " stall"}, MDU_Stall, 1);
        @(negedge clk);
        start = 0; MDUOp = 0; n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({name, " busy_cycles"}, n, n_exp);
    endtask

    initial begin
        int n;
        v[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1};
        v[1]  = '{4'd1,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1};
        v[2]  = '{4'd5,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0};
        v[3]  = '{4'd6,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0};
        v[4]  = '{4'd9,  32'h00000003, 32'h80000000, 5'd1,  32'hF8000000, 1'b0};
        v[5]  = '{4'd7,  32'h0000001F, 32'h00000001, 5'd2,  32'h00000002, 1'b0};
        v[6]  = '{4'd11, 32'h00000000, 32'h00001234, 5'd0,  32'h12340000, 1'b0};
        v[7]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0};
        v[8]  = '{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0};
        v[9]  = '{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0};
        v[10] = '{4'd10, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 1'b0};
        v[11] = '{4'd8,  32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0};
        v[12] = '{4'd0,  32'h00000001, 32'h00000002, 5'd0,  32'h00000003, 1'b0};
        v[13] = '{4'd12, 32'h00000005, 32'h00000006, 5'd0,  32'h00000000, 1'b0};
        v[14] = '{4'd1,  32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b1};
        v[15] = '{4'd0,  32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1'b1};

        for (int i = 0; i < 16; i++) begin
            ALUCtrl = v[i].ctrl; A = v[i].a; B = v[i].b; shamt = v[i].sh;
            #1;
            chk($sformatf("alu[%0d] result", i), ALU_Result, v[i].res);
            chk($sformatf("alu[%0d] overflow", i), Overflow, v[i].ov);
        end
        ALUCtrl = 0; A = 0; B = 0; shamt = 0;

        ctl8 = 4'd9; b8 = 8'h80; a8 = 8'd6; sh8 = 3'd3;
        #1 chk("w8 sra wrap 9", alu8, 8'hC0);
        a8 = 8'd7; sh8 = 3'd7;
        #1 chk("w8 sra wrap 14", alu8, 8'hFE);

        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset hi", HI, 0);
        chk("reset lo", LO, 0);
        chk("reset stall", MDU_Stall, 0);
        chk("reset mdu_result", MDU_Result, 0);
        reset_n = 1;
        @(negedge clk);

        run_op("mult", 4'd1, 32'hFFFFFFFF, 32'h2, 5);
        chk("mult hi", HI, 32'hFFFFFFFF);
        chk("mult lo", LO, 32'hFFFFFFFE);
        start = 1; MDUOp = 4'd5;
        #1 chk("mfhi at busy fall", MDU_Result, 32'hFFFFFFFF);
        chk("mfhi no stall", MDU_Stall, 0);
        MDUOp = 4'd6;
        #1 chk("mflo at busy fall", MDU_Result, 32'hFFFFFFFE);
        start = 0; MDUOp = 0;
        #1 chk("mdu_result idle", MDU_Result, 0);
        @(negedge clk);

        run_op("multu", 4'd2, 32'hFFFFFFFF, 32'h2, 5);
        chk("multu hi", HI, 32'h1);
        chk("multu lo", LO, 32'hFFFFFFFE);
        run_op("div", 4'd3, 32'hFFFFFFF9, 32'h2, 10);
        chk("div hi", HI, 32'hFFFFFFFF);
        chk("div lo", LO, 32'hFFFFFFFD);
        run_op("divu0", 4'd4, 32'h7, 32'h0, 10);
        chk("divu0 hi", HI, 32'hFFFFFFFF);
        chk("divu0 lo", LO, 32'hFFFFFFFD);

        start = 1; MDUOp = 4'd7; A = 32'hAAAA0000;
        #1 chk("mthi old hi", HI, 32'hFFFFFFFF);
        chk("mthi stall", MDU_Stall, 0);
        @(negedge clk);
        chk("mthi new hi", HI, 32'hAAAA0000);
        chk("mthi busy", busy, 0);
        MDUOp = 4'd8; A = 32'h5555;
        @(negedge clk);
        start = 0; MDUOp = 0;
        chk("mtlo new lo", LO, 32'h5555);

        A = 32'h3; B = 32'hFFFFFFFB; MDUOp = 4'd1; start = 1;
        @(negedge clk);
        MDUOp = 4'd3; A = 32'd100; B = 32'd7;
        #1 chk("ignore stall", MDU_Stall, 1);
        @(negedge clk);
        MDUOp = 4'd8; A = 32'h1234;
        @(negedge clk);
        start = 0; MDUOp = 0; n = 2;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("ignore busy_cycles", n, 5);
        chk("ignore hi", HI, 32'hFFFFFFFF);
        chk("ignore lo", LO, 32'hFFFFFFF1);

        run_op("b2b div", 4'd3, 32'h7, 32'hFFFFFFFE, 10);
        chk("b2b div hi", HI, 32'h1);
        chk("b2b div lo", LO, 32'hFFFFFFFD);

        A = 32'd100; B = 32'd7; MDUOp = 4'd3; start = 1;
        @(negedge clk);
        start = 0; MDUOp = 0;
        repeat (7) @(negedge clk);
        chk("pre-reset busy", busy, 1);
        reset_n = 0;
        #1 chk("midrun reset busy", busy, 0);
        chk("midrun reset hi", HI, 0);
        chk("midrun reset lo", LO, 0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        run_op("multu after reset", 4'd2, 32'd3, 32'd4, 5);
        chk("multu after reset hi", HI, 0);
        chk("multu after reset lo", LO, 32'd12);

        a16 = 16'h8000; b16 = 16'h8000; op16 = 4'd1; start16 = 1;
        #1 chk("w16 stall", stall16, 1);
        @(negedge clk);
        start16 = 0; op16 = 0; n = 0;
        while (busy16 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("w16 busy_cycles", n, 1);
        chk("w16 hi", hi16, 16'h4000);
        chk("w16 lo", lo16, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/e_alu_mdu.md
# e_alu_mdu

Parametrised execute-stage unit for the pipelined MIPS core. It merges the combinational ALU with a multi-cycle multiply/divide unit (MDU) that owns the HI/LO registers. The ALU gains a signed-overflow flag and a LUI mode. The MDU emits busy/stall signals so the hazard unit can freeze the E stage while a MULT/DIV is in flight.

## Interface
- WIDTH, 32, datapath width; must be even and ≥ 8
- SHW, $clog2(WIDTH), shift-amount width
- MUL_CYCLES, 5, busy cycles for MULT/MULTU; must be ≥ 1
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be ≥ 1
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- A, B  in  WIDTH  operands (rs, rt after forwarding)
- shamt  in  SHW  instruction shift field
- ALUCtrl  in  4  ALU op: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, NOR=10, LUI=11; others → 0
- ALU_Result  out  WIDTH  combinational ALU result
- Overflow  out  1  signed overflow for ADD/SUB only, else 0
- MDUOp  in  4  NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; others = NONE
- start  in  1  qualifies MDUOp this cycle
- busy  out  1  registered; MDU computing
- MDU_Stall  out  1  combinational: busy | (start & MDUOp ∈ 1..4)
- MDU_Result  out  WIDTH  combinational: HI for MFHI, LO for MFLO, else 0
- HI, LO  out  WIDTH  architectural registers

## Operation
- ALU is purely combinational, unaffected by clock, reset or busy.
- Shift amount is (A[SHW-1:0] + shamt) mod WIDTH.
  - SLL / SRL are logical shifts of B.
  - SRA is an arithmetic shift of B.
- LUI: B << (WIDTH/2).
- SLT compares A and B signed; SLTU compares them unsigned. The result is 1 or 0, zero-extended.
- Overflow flag:
  - ADD: set when the operand signs are equal and the result sign differs.
  - SUB: set when the operand signs differ and the result sign differs from A.
  - ALU_Result is the wrapped value regardless of the flag.
- MDU FSM has two states, IDLE and RUN, with a down-counter cnt.
- IDLE + start + MDUOp ∈ 1..4:
  - Latch A, B and the op.
  - cnt ← MUL_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN: cnt decrements each cycle. At the edge where cnt reaches 0, write HI/LO and return to IDLE.
- MULT / MULTU: compute the 2·WIDTH-bit product, signed or unsigned; HI = upper half, LO = lower half.
- DIV / DIVU:
  - LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divisor 0: HI/LO unchanged, busy timing unchanged.
- MTHI / MTLO with start in IDLE: HI←A or LO←A at that edge; no busy.
- MFHI / MFLO: read HI/LO combinationally; never blocked.
- Any start in RUN is ignored, including MTHI/MTLO. The pipeline does not issue one, because MDU_Stall is high.
- reset_n low at any time, including mid-RUN:
  - HI, LO, cnt, busy ← 0, FSM ← IDLE.
  - The in-flight operation is discarded.

## Timing
- Reset values: busy=0, HI=0, LO=0. MDU_Stall=0 and MDU_Result=0 while start=0.
- Start sampled at edge t:
  - busy=1 after edge t.
  - busy=0 after edge t+N (N = MUL_CYCLES or DIV_CYCLES), with HI/LO updated at edge t+N.
  - busy is therefore high for exactly N cycles.
- MDU_Stall is high in the start cycle, before busy rises, so no bubble escapes.
- A new MULT/DIV may start in the first cycle after busy falls. Back-to-back ops give N+1-cycle spacing, counting the start cycle.
- MFHI issued in the cycle busy falls reads the new value.
- MTHI in IDLE: MFHI in the same cycle reads the old HI, and in the next cycle reads A.

## Test plan
- ALU sweep, WIDTH=32:
  - ADD 0x7FFFFFFF + 1 → 0x80000000, Overflow=1.
  - SUB 0x80000000 − 1 → 0x7FFFFFFF, Overflow=1.
  - SLT −1 vs 1 → 1; SLTU → 0.
  - SRA 0x80000000 with A=3, shamt=1 → 0xF8000000.
  - Shift wrap: A[4:0]=31, shamt=2 → shift by 1.
  - LUI 0x1234 → 0x12340000.
- MULT 0xFFFFFFFF × 2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=1, LO=0xFFFFFFFE. busy is high exactly 5 cycles and MDU_Stall is high in the start cycle.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → HI/LO unchanged, busy for 10 cycles.
- Start a DIV while busy from a prior MULT, and MTLO while busy → both ignored; HI/LO reflect only the MULT.
- reset_n low for 1 cycle at cnt=3 of a DIV → busy=0, HI=LO=0 immediately. A MULTU 3×4 issued afterwards gives LO=12 after 5 cycles.
- Parameter variants:
  - WIDTH=16, MUL_CYCLES=1: MULT 0x8000 × 0x8000 → HI=0x4000, LO=0, busy for 1 cycle.
  - WIDTH=8: SRA wraps modulo 8.
